// File: rtl/spi_pkg.sv
// Shared SPI link definitions for spi_master / spi_slave.
package spi_pkg;
    localparam int SPI_DATA_W = 16;
    localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

    typedef enum logic {IDLE, ACTIVE} spi_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered one-clk rise/fall pulses.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~prev;
            fall  <= ~chain[STAGES-1] & prev;
        end
    end
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled SCLK/CS_N/MOSI, full-duplex 16-bit words in the clk domain.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    output logic              miso_oe,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              rx_ack,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              overrun,
    output logic              frame_err,
    input  logic              clr_status
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    spi_state_t             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift, tx_shift;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   word_done;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset_n(reset_n), .din(SCLK), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset_n(reset_n), .din(CS_N), .rise(cs_rise), .fall(cs_fall)
    );

    assign busy    = (state == ACTIVE);
    assign miso_oe = busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            mosi_sync  <= '0;
            word_done  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            MISO       <= 1'b0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            word_done <= 1'b0;
            frame_err <= 1'b0;

            // A completing word beats a same-cycle ack, so valid stays set.
            if (word_done) begin
                data_out   <= rx_shift;
                data_valid <= 1'b1;
            end else if (rx_ack) begin
                data_valid <= 1'b0;
            end

            if (word_done && data_valid && !rx_ack)
                overrun <= 1'b1;
            else if (clr_status)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        tx_shift <= tx_data;
                        bit_cnt  <= '0;
                        MISO     <= tx_data[DATA_W-1];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        MISO      <= 1'b0;
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync[SYNC_STAGES-1]};
                            if (bit_cnt == LAST) begin
                                bit_cnt   <= '0;
                                word_done <= 1'b1;
                                tx_shift  <= tx_data;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // Fall right after a word boundary presents the freshly loaded MSB.
                        if (sclk_fall) begin
                            if (bit_cnt != '0) begin
                                tx_shift <= tx_shift << 1;
                                MISO     <= tx_shift[DATA_W-2];
                            end else begin
                                MISO <= tx_shift[DATA_W-1];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed cases plus randomized frames vs a word-level model.
module tb_spi_slave;
    localparam int W    = 16;
    localparam int SS   = 2;
    localparam int HALF = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          SCLK = 1'b0, CS_N = 1'b1, MOSI = 1'b0;
    logic          MISO, miso_oe, data_valid, busy, overrun, frame_err;
    logic [W-1:0]  data_out;
    logic          rx_ack = 1'b0, clr_status = 1'b0;
    logic [W-1:0]  tx_data = '0;

    spi_slave #(.DATA_W(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
        .MISO(MISO), .miso_oe(miso_oe), .data_out(data_out), .data_valid(data_valid),
        .rx_ack(rx_ack), .tx_data(tx_data), .busy(busy), .overrun(overrun),
        .frame_err(frame_err), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, last_rise_cyc = 0, valid_rise_cyc = -1, fe_cnt = 0;
    logic dv_q = 1'b0;

    // reference model: word-level view of the receive side
    logic [W-1:0] exp_dout = '0;
    logic         exp_dv = 1'b0, exp_ovr = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (data_valid && !dv_q) valid_rise_cyc = cyc;
        dv_q = data_valid;
        if (frame_err) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dout"}, 32'(data_out), 32'(exp_dout));
        chk({tag, ".dv"},   32'(data_valid), 32'(exp_dv));
        chk({tag, ".ovr"},  32'(overrun), 32'(exp_ovr));
    endtask

    task automatic model_word(input logic [W-1:0] w);
        if (exp_dv) exp_ovr = 1'b1;
        exp_dout = w;
        exp_dv   = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge that drops SCLK after the last bit.
    task automatic send_word(input logic [W-1:0] w, input int nbits,
                             input logic [W-1:0] next_tx, output logic [W-1:0] mw);
        mw = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[W-1-i];
            repeat (HALF) @(negedge clk);
            mw[W-1-i] = MISO;
            SCLK = 1'b1;
            if (i == W-1) last_rise_cyc = cyc + 1;
            if (i == 0) tx_data = next_tx;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic start_frame(input logic [W-1:0] tx);
        tx_data = tx;
        CS_N = 1'b0;
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        CS_N = 1'b1;
        repeat (HALF + 2) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_dv = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        exp_ovr = 1'b0;
    endtask

    logic [W-1:0] mw;
    int           fe0;

    initial begin
        // 1: reset held, inputs wiggling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            SCLK = ~SCLK;
            MOSI = 1'($urandom);
        end
        SCLK = 1'b0;
        chk("rst.miso", 32'(MISO), 0);
        chk("rst.oe",   32'(miso_oe), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.fe",   32'(frame_err), 0);
        chk_model("rst");
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // 2: single word, latency and MISO
        start_frame(16'hA5A5);
        send_word(16'h0404, W, 16'h0000, mw);
        model_word(16'h0404);
        chk("t2.lat", 32'(valid_rise_cyc - last_rise_cyc), SS + 2);
        chk("t2.miso", 32'(mw), 32'h0000A5A5);
        chk("t2.busy", 32'(busy), 1);
        chk("t2.oe", 32'(miso_oe), 1);
        end_frame();
        chk_model("t2");
        chk("t2.idle_oe", 32'(miso_oe), 0);
        chk("t2.idle_miso", 32'(MISO), 0);
        pulse_ack();
        @(negedge clk);
        chk_model("t2ack");

        // 3: back-to-back under one CS_N with acks
        start_frame(16'h1357);
        send_word(16'h00FF, W, 16'h9BDF, mw);
        model_word(16'h00FF);
        chk("t3.miso0", 32'(mw), 32'h1357);
        chk_model("t3.w0");
        pulse_ack();
        send_word(16'hAA55, W, 16'h0000, mw);
        model_word(16'hAA55);
        chk("t3.miso1", 32'(mw), 32'h9BDF);
        chk_model("t3.w1");
        pulse_ack();
        end_frame();
        chk_model("t3");

        // 4: two words without ack -> overrun
        start_frame(16'h0000);
        send_word(16'h00FF, W, 16'h0000, mw);
        model_word(16'h00FF);
        send_word(16'hAA55, W, 16'h0000, mw);
        model_word(16'hAA55);
        end_frame();
        chk("t4.ovr", 32'(overrun), 1);
        chk_model("t4");
        pulse_clr();
        @(negedge clk);
        chk_model("t4clr");

        // 5: abort after 7 bits
        fe0 = fe_cnt;
        start_frame(16'hFFFF);
        send_word(16'h8001, 7, 16'h0000, mw);
        end_frame();
        chk("t5.fe", 32'(fe_cnt - fe0), 1);
        chk_model("t5");

        // 6: reset mid-transfer
        pulse_ack();
        start_frame(16'h1111);
        send_word(16'h1234, 9, 16'h0000, mw);
        reset_n = 1'b0;
        CS_N = 1'b1;
        exp_dout = '0; exp_dv = 1'b0; exp_ovr = 1'b0;
        repeat (3) @(negedge clk);
        chk_model("t6rst");
        chk("t6.busy", 32'(busy), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        fe0 = fe_cnt;
        start_frame(16'h0F0F);
        send_word(16'h5678, W, 16'h0000, mw);
        model_word(16'h5678);
        end_frame();
        chk_model("t6");
        chk("t6.miso", 32'(mw), 32'h0F0F);
        chk("t6.fe", 32'(fe_cnt - fe0), 0);
        pulse_ack();

        // randomized frames
        for (int r = 0; r < 12; r++) begin
            int           nw;
            bit           abort;
            logic [W-1:0] txv [4];
            nw = $urandom_range(1, 3);
            abort = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) txv[k] = W'($urandom);
            fe0 = fe_cnt;
            start_frame(txv[0]);
            for (int k = 0; k < nw; k++) begin
                logic [W-1:0] w;
                w = W'($urandom);
                if (abort && k == nw - 1) begin
                    send_word(w, $urandom_range(1, W-1), txv[k+1], mw);
                end else begin
                    send_word(w, W, txv[k+1], mw);
                    model_word(w);
                    chk($sformatf("rnd%0d.miso%0d", r, k), 32'(mw), 32'(txv[k]));
                    if ($urandom_range(0, 1) == 1) pulse_ack();
                end
            end
            end_frame();
            chk($sformatf("rnd%0d.fe", r), 32'(fe_cnt - fe0), abort ? 1 : 0);
            if ($urandom_range(0, 3) == 0) pulse_clr();
            @(negedge clk);
            chk_model($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
